// File: rtl/reg_file_reader.sv
// Streams a block of consecutive registers from a 16x32 register file read mux
// onto a valid/ready output port, one beat per cycle when the consumer is ready.
module reg_file_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  first_reg,
    input  logic [4:0]  count,
    output logic [3:0]  rd_sel,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_ptr;
    logic [4:0]  r_remaining;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [3:0]  r_out_index;
    logic        r_out_last;

    logic        w_load;
    logic        w_xfer;
    logic        w_start_block;
    logic [4:0]  w_count_clamped;

    assign w_count_clamped = (count > 5'd16) ? 5'd16 : count;
    assign w_start_block   = (r_state == S_IDLE) && start && (count != 5'd0);
    assign w_xfer          = r_out_valid && out_ready;
    // The output register refills whenever it is empty or being drained this edge.
    assign w_load          = (r_state == S_STREAM) && (r_remaining != 5'd0) &&
                             (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (count == 5'd0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && r_out_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_start_block) begin
                r_ptr       <= first_reg;
                r_remaining <= w_count_clamped;
            end
            if (w_load) begin
                r_out_data  <= rd_data;
                r_out_index <= r_ptr;
                r_out_last  <= (r_remaining == 5'd1);
                r_out_valid <= 1'b1;
                r_ptr       <= r_ptr + 4'd1;
                r_remaining <= r_remaining - 5'd1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rd_sel    = r_ptr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign busy      = (r_state == S_STREAM);
    assign done      = (r_state == S_FINISH);

endmodule

// File: doc/reg_file_reader.md
REG_FILE_READER -- requirements
Module: reg_file_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports exactly as listed below.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 start  in  1  request to stream a block of registers; honoured only in IDLE.
REQ-005 first_reg  in  4  index of the first register to read; sampled with start.
REQ-006 count  in  5  number of registers to read; sampled with start.
REQ-007 rd_sel  out  4  select driven to the 16x32 register file read mux.
REQ-008 rd_data  in  32  read-mux output; a combinational function of rd_sel in the same cycle.
REQ-009 out_valid  out  1  out_data, out_index and out_last are valid.
REQ-010 out_ready  in  1  consumer accepts a beat; a transfer occurs when out_valid && out_ready at a rising edge.
REQ-011 out_data  out  32  captured register value.
REQ-012 out_index  out  4  register index of out_data.
REQ-013 out_last  out  1  current beat is the final beat of the block.
REQ-014 busy  out  1  high in STREAM.
REQ-015 done  out  1  one-cycle pulse, high in FINISH.

Function
REQ-016 The FSM SHALL have the states IDLE, STREAM and FINISH.
REQ-017 IDLE with start=1 and count>=1: latch ptr=first_reg and remaining=min(count,16), then enter STREAM.
REQ-018 IDLE with start=1 and count=0: enter FINISH and produce no beats.
REQ-019 start outside IDLE SHALL be ignored and has no effect.
REQ-020 rd_sel SHALL equal the ptr register at all times.
REQ-021 Load condition, in STREAM: remaining>0 && (!out_valid || out_ready).
REQ-022 On load: out_data<=rd_data, out_index<=ptr, out_last<=(remaining==1), out_valid<=1, ptr<=ptr+1 mod 16 (15 wraps to 0), remaining<=remaining-1.
REQ-023 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-024 Latency: start sampled at edge N gives first out_valid=1 after edge N+1.
REQ-025 Backpressure: while out_valid=1 and out_ready=0, out_data, out_index, out_last and ptr SHALL hold unchanged.
REQ-026 A transfer with no load in the same cycle SHALL clear out_valid.
REQ-027 A transfer of the beat with out_last=1 SHALL move the FSM to FINISH, with out_valid=0 after that edge.
REQ-028 FINISH: done=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-029 A start asserted during FINISH SHALL be ignored.
REQ-030 count values 17..31 SHALL be clamped to 16 beats.
REQ-031 A full 16-beat block SHALL read each register exactly once.
REQ-032 Beats from one block SHALL never mix with another block; at most one block is in flight.

Reset
REQ-033 A rising edge with reset=1 SHALL set the FSM to IDLE, ptr/rd_sel=0, remaining=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
REQ-034 Reset SHALL take priority over all other inputs, including mid-STREAM and during FINISH.
REQ-035 A reset during STREAM SHALL abort the block with no further beats and no done pulse.

Verification
REQ-036 Register file preloaded with Rk=32'hA000_000k; start, first_reg=2, count=3, out_ready=1 -> beats (2,A0000002), (3,A0000003), (4,A0000004,last) on consecutive cycles; done pulses one cycle after the last beat.
REQ-037 first_reg=14, count=4 -> out_index sequence 14,15,0,1 with out_last on index 1.
REQ-038 count=0 -> no out_valid; done=1 on the cycle after start; busy stays 0.
REQ-039 count=20, first_reg=0 -> exactly 16 beats, indices 0..15; out_last on index 15.
REQ-040 first_reg=5, count=3, out_ready toggled 0,0,1,0,1,1 -> each beat held stable while stalled; data 5,6,7 in order with no loss or duplication.
REQ-041 reset asserted after the 2nd beat of a 6-beat block -> out_valid=0 and rd_sel=0 on the next cycle; no done pulse; a new start afterwards streams correctly.
